// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters plus registered sync, blank and RGB. Optional border macro: VGA_BORDER_EN.
// Latency: sync/blank/RGB lag oCoord_X/oCoord_Y by exactly one enable period; coordinates have no added latency.
// Backpressure: none; state advances only on enable strobes and holds on every clock where enable is low.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] iRed,
  input  logic [7:0] iGreen,
  input  logic [7:0] iBlue,
  output logic [9:0] oCoord_X,
  output logic [9:0] oCoord_Y,
  output logic [7:0] oVGA_R,
  output logic [7:0] oVGA_G,
  output logic [7:0] oVGA_B,
  output logic       oVGA_H_SYNC,
  output logic       oVGA_V_SYNC,
  output logic       oVGA_BLANK,
  output logic       oVGA_SYNC
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // All geometry constants are pre-cast to the 10-bit counter width.
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       visible;
  logic       hs_raw;
  logic       vs_raw;
  logic [7:0] red_nxt;
  logic [7:0] green_nxt;
  logic [7:0] blue_nxt;

  // Pixel and line counters advance once per enable strobe; v wraps on the same strobe as h.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (enable) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Decode the current counter position into visibility, raw syncs and the pixel colour to latch.
  always_comb begin
    visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hs_raw    = !((h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END));
    vs_raw    = !((v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END));
    red_nxt   = 8'h00;
    green_nxt = 8'h00;
    blue_nxt  = 8'h00;
    if (visible) begin
      red_nxt   = iRed;
      green_nxt = iGreen;
      blue_nxt  = iBlue;
`ifdef VGA_BORDER_EN
      // Outermost visible ring is forced white, whatever colour the source supplies.
      if ((h_cnt == 10'd0) || (h_cnt == H_VIS - 10'd1) ||
          (v_cnt == 10'd0) || (v_cnt == V_VIS - 10'd1)) begin
        red_nxt   = 8'hFF;
        green_nxt = 8'hFF;
        blue_nxt  = 8'hFF;
      end
`endif
    end
  end

  // Register sync, blank and colour together so they stay mutually aligned one pixel late.
  always_ff @(posedge clock) begin
    if (reset) begin
      oVGA_H_SYNC <= 1'b1;
      oVGA_V_SYNC <= 1'b1;
      oVGA_BLANK  <= 1'b0;
      oVGA_R      <= 8'h00;
      oVGA_G      <= 8'h00;
      oVGA_B      <= 8'h00;
    end else if (enable) begin
      oVGA_H_SYNC <= hs_raw;
      oVGA_V_SYNC <= vs_raw;
      oVGA_BLANK  <= visible;
      oVGA_R      <= red_nxt;
      oVGA_G      <= green_nxt;
      oVGA_B      <= blue_nxt;
    end
  end

  assign oCoord_X  = h_cnt;
  assign oCoord_Y  = v_cnt;
  assign oVGA_SYNC = 1'b0;

endmodule
